picoblaze_io_bank: RTL

//  Parametrised KCPSM6 port-I/O bank: N input bytes, M output byte registers, edge-latched event flags and interrupt.

---
 rtl/picoblaze_io_bank.sv | 138 +++++++++++++
 1 files changed

// File: rtl/picoblaze_io_bank.sv
// picoblaze_io_bank: KCPSM6 port-I/O bank with NUM_IN input bytes, NUM_OUT output
// byte registers, edge-latched event flags with write-1-to-clear, and a maskable
// interrupt request.
// Optional feature macro: IO_READBACK_EN makes the output registers and the mask
// register readable at their own addresses. When it is undefined those addresses
// read as 8'h00 and the readback mux is not built.
module picoblaze_io_bank #(
  parameter int         NUM_IN    = 2,
  parameter int         NUM_OUT   = 4,
  parameter logic [7:0] IN_BASE   = 8'h00,
  parameter logic [7:0] OUT_BASE  = 8'h02,
  parameter logic [7:0] EVT_ADDR  = 8'hF0,
  parameter logic [7:0] MASK_ADDR = 8'hF1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           port_id,
  input  logic                 write_strobe,
  input  logic                 read_strobe,
  input  logic [7:0]           out_port,
  output logic [7:0]           in_port,
  input  logic [8*NUM_IN-1:0]  in_data,
  output logic [8*NUM_OUT-1:0] out_data,
  input  logic [7:0]           evt_in,
  output logic                 interrupt,
  input  logic                 interrupt_ack
);

  localparam int IN_LO  = int'(IN_BASE);
  localparam int IN_HI  = IN_LO + NUM_IN;
  localparam int OUT_LO = int'(OUT_BASE);
  localparam int OUT_HI = OUT_LO + NUM_OUT;
  localparam int EVT_A  = int'(EVT_ADDR);
  localparam int MASK_A = int'(MASK_ADDR);

  function automatic bit in_range(input int a, input int lo, input int hi);
    return (a >= lo) && (a < hi);
  endfunction

  // The four address regions must be disjoint and fit in the 8-bit port space.
  localparam bit BAD_PARAMS =
      (NUM_IN < 1) || (NUM_IN > 16) || (NUM_OUT < 1) || (NUM_OUT > 16) ||
      (IN_HI > 256) || (OUT_HI > 256) ||
      ((IN_LO < OUT_HI) && (OUT_LO < IN_HI)) ||
      in_range(EVT_A, IN_LO, IN_HI) || in_range(EVT_A, OUT_LO, OUT_HI) ||
      in_range(MASK_A, IN_LO, IN_HI) || in_range(MASK_A, OUT_LO, OUT_HI) ||
      (EVT_A == MASK_A);

  generate
    if (BAD_PARAMS) begin : g_param_error
      $error("picoblaze_io_bank: illegal sizes or overlapping port address ranges");
    end
  endgenerate

  // read_strobe carries no side effects; the read path is a plain registered mux.
  logic unused_read_strobe;
  assign unused_read_strobe = read_strobe;

  logic [7:0] mask;
  logic [7:0] evt_flags;
  logic [7:0] s1, s2, s3;
  logic [7:0] rise;
  logic [7:0] evt_clear;
  logic       new_req;
  logic       req_q;
  logic [7:0] rd_data;

  assign rise      = s2 & ~s3;
  assign new_req   = |(rise & mask);
  assign evt_clear = (write_strobe && (port_id == EVT_ADDR)) ? out_port : 8'h00;

  // Read mux: selects the byte addressed by port_id, zero for unmapped ports.
  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(port_id) == IN_LO + i) rd_data = in_data[8*i +: 8];
    end
    if (port_id == EVT_ADDR) rd_data = evt_flags;
`ifdef IO_READBACK_EN
    for (int j = 0; j < NUM_OUT; j++) begin
      if (int'(port_id) == OUT_LO + j) rd_data = out_data[8*j +: 8];
    end
    if (port_id == MASK_ADDR) rd_data = mask;
`endif
  end

  // Registered read data, giving the one-cycle INPUT latency KCPSM6 expects.
  always_ff @(posedge clk) begin
    if (rst) in_port <= 8'h00;
    else     in_port <= rd_data;
  end

  // Output byte registers and interrupt mask, written on write_strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      mask     <= 8'h00;
    end else if (write_strobe) begin
      for (int j = 0; j < NUM_OUT; j++) begin
        if (int'(port_id) == OUT_LO + j) out_data[8*j +: 8] <= out_port;
      end
      if (port_id == MASK_ADDR) mask <= out_port;
    end
  end

  // Two-flop synchronizer plus a delay flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 8'h00;
      s2 <= 8'h00;
      s3 <= 8'h00;
    end else begin
      s1 <= evt_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Event flags: a fresh rising edge sets a bit and beats a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (rst) evt_flags <= 8'h00;
    else     evt_flags <= (evt_flags & ~evt_clear) | rise;
  end

  // Interrupt: raised the edge after a masked rising edge, dropped by ack
  // unless a new request arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q     <= 1'b0;
      interrupt <= 1'b0;
    end else begin
      req_q <= new_req;
      if (req_q)              interrupt <= 1'b1;
      else if (interrupt_ack) interrupt <= 1'b0;
    end
  end

endmodule
